// File: rtl/example.sv
// Two-stage AES SubWord pipeline: samples one 32-bit word per clock and
// emits the parity of its S-box substitution two edges later.
module example #(
  parameter int unsigned MSG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MSG_WIDTH-1:0] msg,
  output logic                 out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [MSG_WIDTH-1:0] in_q,  in_d;
  logic [MSG_WIDTH-1:0] sub_q, sub_d;
  logic                 out_q, out_d;

  always_comb begin
    in_d  = msg;
    sub_d = '0;
    // Bytes substituted in place, no rotation.
    for (int unsigned b = 0; b < MSG_WIDTH / 8; b++) begin
      sub_d[8*b +: 8] = SBOX[in_q[8*b +: 8]];
    end
    out_d = ^sub_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q  <= '0;
      sub_q <= '0;
      out_q <= 1'b0;
    end else begin
      in_q  <= in_d;
      sub_q <= sub_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_example.sv
// Directed and random checks of the SubWord parity pipeline against a
// reference S-box computed from GF(2^8) inversion plus the AES affine map.
module tb_example;

  logic        clk;
  logic        reset;
  logic [31:0] msg;
  logic        out;

  int unsigned tests;
  int unsigned errors;

  example #(.MSG_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .msg   (msg),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (observed running, required done)");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    // v^254 is the multiplicative inverse; 0 maps to 0.
    for (int i = 0; i < 254; i++) r = gmul(r, v);
    if (v == 8'h00) r = 8'h00;
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic par_ref(input logic [31:0] w);
    logic [31:0] s;
    s = {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
    return ^s;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_check(input logic [31:0] w, input logic exp, input string tag);
    msg = w;
    tick();
    check(tag, out, exp);
  endtask

  logic q_par [$];
  int unsigned ones_dut;
  int unsigned ones_model;
  logic [31:0] w;
  logic        e;

  initial begin
    tests  = 0;
    errors = 0;
    reset  = 1'b0;
    msg    = '0;
    #1;
    check("reset_t0", out, 1'b0);

    for (int i = 0; i < 10; i++) begin
      msg = $urandom;
      tick();
      check("reset_hold", out, 1'b0);
    end

    msg = '0;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) drive_check(32'h0, 1'b0, "zero_steady");

    drive_check(32'h00000001, 1'b0, "pulse_k");
    drive_check(32'h00000000, 1'b0, "pulse_k1");
    drive_check(32'h00000000, 1'b1, "pulse_k2");
    drive_check(32'h00000000, 1'b0, "pulse_k3");
    drive_check(32'h00000000, 1'b0, "pulse_k4");

    drive_check(32'h000000FF, 1'b0, "ff_k");
    drive_check(32'h00000000, 1'b0, "ff_k1");
    drive_check(32'h00000000, 1'b1, "ff_k2");
    drive_check(32'h00000053, 1'b0, "s53_k");
    drive_check(32'h00000000, 1'b0, "s53_k1");
    drive_check(32'h00000000, 1'b0, "s53_k2");
    drive_check(32'h00000010, 1'b0, "s10_k");
    drive_check(32'h00000000, 1'b0, "s10_k1");
    drive_check(32'h00000000, 1'b0, "s10_k2");

    drive_check(32'h00000001, 1'b0, "stream0");
    drive_check(32'h00000000, 1'b0, "stream1");
    drive_check(32'h000000FF, 1'b1, "stream2");
    drive_check(32'h00000053, 1'b0, "stream3");
    drive_check(32'h01010101, 1'b1, "stream4");
    drive_check(32'h00000000, 1'b0, "stream5");
    drive_check(32'h00000000, 1'b0, "stream6");

    drive_check(32'h000000FF, 1'b0, "midrst_a");
    drive_check(32'h000000FF, 1'b0, "midrst_b");
    drive_check(32'h000000FF, 1'b1, "midrst_c");
    #3;
    reset = 1'b0;
    #1;
    check("midrst_async", out, 1'b0);
    tick();
    check("midrst_held", out, 1'b0);
    reset = 1'b1;
    drive_check(32'h00000000, 1'b0, "release_e1");
    drive_check(32'h00000000, 1'b0, "release_e2");

    q_par.push_back(1'b0);
    q_par.push_back(1'b0);
    ones_dut   = 0;
    ones_model = 0;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      if (i % 7 == 0) w = {24'h0, 8'($urandom_range(0, 255))};
      q_par.push_back(par_ref(w));
      e = q_par.pop_front();
      msg = w;
      tick();
      check("random", out, e);
      if (out === 1'b1) ones_dut++;
      if (e) ones_model++;
    end
    tests++;
    assert (ones_dut == ones_model) else begin
      errors++;
      $error("FAIL ones_count: observed %0d expected %0d", ones_dut, ones_model);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
